mul_iter_sw: RTL
================

Name: mul_iter_sw

Overview:
- Parametrised, multi-cycle signed/unsigned integer multiplier: WIDTH x WIDTH -> 2*WIDTH.
- Built from CHUNK-bit partial products; each cycle it processes one CHUNK-bit slice of operand b and accumulates.
- Valid/ready handshakes on input and output; one transaction in flight.
- Arithmetic service block for the pi datapath; replaces fixed 32-bit combinational partial-product multipliers where area matters more than latency.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits of operand b consumed per CALC cycle; must be >= 1 and divide WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands a, b and signed_mode are valid.
- in_ready  out  1  block can accept a transaction.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1: two's-complement operands; 0: unsigned.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  2*WIDTH  product.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1, out_valid=0, busy=0, result=0; accumulator and counters cleared. Asserting reset mid-operation aborts the transaction; no partial result is ever presented.
- States and transitions:
  - IDLE -> CALC on in_valid && in_ready.
  - CALC -> SIGN after N = WIDTH/CHUNK cycles.
  - SIGN -> DONE after 1 cycle.
  - DONE -> IDLE on out_ready.
- in_ready = (state == IDLE). There is no accept in the same cycle as the DONE->IDLE transition.
- Accept edge E0 latches:
  - |a| and |b| as WIDTH-bit unsigned magnitudes.
  - neg = signed_mode & (a[W-1] ^ b[W-1]).
  - Accumulator cleared; chunk counter = 0.
- Magnitude rule: in signed mode, operand x with its MSB set becomes (~x + 1) taken as WIDTH-bit unsigned. The most negative value therefore becomes 2^(W-1) exactly, with no loss. Unsigned mode passes operands through unchanged.
- CALC cycle k (k = 0..N-1): acc += (|a| * b_mag[k*CHUNK +: CHUNK]) << (k*CHUNK). The accumulator is 2*WIDTH bits wide and never overflows.
- SIGN: result <= neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits.
- Latency: out_valid rises after edge E0+N+1 (E0+5 for the defaults).
- While out_valid && !out_ready, result and out_valid stay stable indefinitely.
- out_ready while not in DONE is ignored.
- in_valid while busy is ignored; operands are not re-sampled.
- signed_mode=1 with a=0 or b=0 gives result 0, never negative zero. neg may be 1, but ~0+1 wraps to 0.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: in CALC, after processing chunk k, if all bits of |b| above (k+1)*CHUNK are zero, go directly to SIGN.
  - Latency becomes (k_last+1)+1 edges after E0, where k_last is the highest non-zero chunk index.
  - Minimum is one CALC cycle, including the b=0 case.
  - Results are identical to the fixed-latency build.
- Undefined: fixed latency of N+1 edges after E0 for every input.

Decomposition:
- Shared package mul_pkg:
  - State enum encoding: IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3.
  - Function computing N=WIDTH/CHUNK.
  - Function computing the counter width as clog2(N), minimum 1.
- Sub-module mul_chunk_pp: combinational WIDTH x CHUNK unsigned partial-product unit producing WIDTH+CHUNK bits. The FSM top instantiates one.

Test Plan:
1. Signed, WIDTH=32: a=0xFFFFFFFD (-3), b=7 -> result=0xFFFFFFFF_FFFFFFEB. out_valid first high after E0+5.
2. Signed: a=b=0x80000000 -> result=0x40000000_00000000. Unsigned, same operands -> 0x40000000_00000000. Unsigned a=b=0xFFFFFFFF -> 0xFFFFFFFE_00000001.
3. Backpressure: with out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, new in_valid ignored. Then out_ready=1 for 1 cycle -> IDLE, in_ready=1.
4. Reset mid-CALC: assert rst_n=0 two cycles after accept -> out_valid=0, result=0, busy=0 immediately. After release, a=12, b=10 -> result=120.
5. MUL_EARLY_TERM_EN defined: b=5, a=0x1234 -> result=0x5B04, out_valid after E0+2. b=0x01000000 -> after E0+5. b=0 -> result 0 after E0+2.
6. Parameter sweep WIDTH=16, CHUNK=4: 500 random signed and unsigned pairs, checked against a reference model -> all match; latency 5 edges without the macro.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative chunked multiplier.
// State codes and sizing helpers used by mul_iter_sw.
package mul_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  function automatic int num_chunks(
    input int width,
    input int chunk
  );
    return width / chunk;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_iter_sw_if.sv
// Operand/result valid-ready bundle for mul_iter_sw.
// master drives operands and out_ready; slave is the multiplier.
interface mul_iter_sw_if #(
  parameter int WIDTH = 32
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/mul_chunk_pp.sv
// Unsigned WIDTH x CHUNK partial product, purely combinational.
// The product always fits in WIDTH+CHUNK bits.
module mul_chunk_pp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [CHUNK-1:0]       b,
  output logic [WIDTH+CHUNK-1:0] p
);

  logic [WIDTH+CHUNK-1:0] a_ext;
  logic [WIDTH+CHUNK-1:0] b_ext;

  assign a_ext = (WIDTH+CHUNK)'(a);
  assign b_ext = (WIDTH+CHUNK)'(b);
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/mul_iter_sw.sv
// Iterative signed/unsigned multiplier, one CHUNK of b per cycle.
// Define MUL_EARLY_TERM_EN to stop once the remaining b bits are zero.
module mul_iter_sw
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic clk,
  input  logic rst_n,
  mul_iter_sw_if.slave bus,
  output logic busy
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]           state;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_sh;
  logic                 neg;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [2*WIDTH-1:0]   result_q;
  logic [WIDTH+CHUNK-1:0] pp;
  logic                 calc_end;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x,
    input logic             sm
  );
    return (sm && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  mul_chunk_pp #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) u_pp (
    .a(a_mag),
    .b(b_sh[CHUNK-1:0]),
    .p(pp)
  );

  assign pp_ext = (2*WIDTH)'(pp) << (CHUNK * int'(cnt));

`ifdef MUL_EARLY_TERM_EN
  // b_sh is already shifted down to chunk cnt; nothing above it -> done
  logic [WIDTH-1:0] b_rest;
  assign b_rest   = b_sh >> CHUNK;
  assign calc_end = (cnt == LAST) || (b_rest == '0);
`else
  assign calc_end = (cnt == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_mag    <= '0;
      b_sh     <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_mag <= mag(bus.a, bus.signed_mode);
            b_sh  <= mag(bus.b, bus.signed_mode);
            neg   <= bus.signed_mode &
                     (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc + pp_ext;
          b_sh <= b_sh >> CHUNK;
          cnt  <= cnt + 1'b1;
          if (calc_end) state <= SIGN;
        end
        SIGN: begin
          result_q <= neg ? (~acc + 1'b1) : acc;
          state    <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign busy          = (state != IDLE);

endmodule
